// File: rtl/impix_system_pio_arbiter.sv
// impix_system_pio_arbiter: two-master round-robin arbiter sharing one output PIO slave
module impix_system_pio_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_waitrequest,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_waitrequest,
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic                  s_chipselect,
  output logic                  s_write_n,
  output logic [DATA_WIDTH-1:0] s_writedata,
  input  logic [DATA_WIDTH-1:0] s_readdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_nx;
  logic m0_req, m1_req, sel, sel_wr, gnt, last_grant, wr;
  logic [DATA_WIDTH-1:0] rd_reg;
  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;
  assign m0_readdata = rd_reg;
  assign m1_readdata = rd_reg;
  assign m0_waitrequest = !(state == RESP && !gnt);
  assign m1_waitrequest = !(state == RESP && gnt);
  always_comb begin
    sel = (m0_req & m1_req) ? ~last_grant : m1_req;
    sel_wr = sel ? m1_write : m0_write;
    state_nx = state == IDLE ? ((m0_req | m1_req) ? ISSUE : IDLE) :
               state == ISSUE ? RESP : IDLE;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // The slave command registers double as the latched transaction fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt <= 1'b0;
      last_grant <= 1'b1;
      wr <= 1'b0;
      rd_reg <= '0;
      s_chipselect <= 1'b0;
      s_write_n <= 1'b1;
      s_address <= '0;
      s_writedata <= '0;
    end else begin
      s_chipselect <= 1'b0;
      s_write_n <= 1'b1;
      if (state == IDLE && (m0_req | m1_req)) begin
        gnt <= sel;
        last_grant <= sel;
        wr <= sel_wr;
        s_chipselect <= 1'b1;
        s_write_n <= ~sel_wr;
        s_address <= sel ? m1_address : m0_address;
        s_writedata <= sel ? m1_writedata : m0_writedata;
      end
      if (state == ISSUE && !wr) rd_reg <= s_readdata;
    end
  end
endmodule

// File: tb/tb_impix_system_pio_arbiter.sv
// tb_impix_system_pio_arbiter: directed bench with a 4-bit output PIO model on the slave side
module tb_impix_system_pio_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] m0_address = '0, m1_address = '0, s_address;
  logic m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0, m0_readdata, m1_readdata;
  logic m0_waitrequest, m1_waitrequest, s_chipselect, s_write_n;
  logic [31:0] s_writedata, s_readdata;
  logic [3:0] out_port;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  impix_system_pio_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata)
  );

  always @(posedge clk)
    if (reset) out_port <= 4'h0;
    else if (s_chipselect && !s_write_n && s_address == 2'd0) out_port <= s_writedata[3:0];
  assign s_readdata = (s_address == 2'd0) ? {28'h0, out_port} : 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (s_chipselect !== 1'b0 || s_write_n !== 1'b1 || s_address !== 2'd0 || s_writedata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_slave: cs=%b wn=%b addr=%0d wd=%h required cs=0 wn=1 addr=0 wd=0", s_chipselect, s_write_n, s_address, s_writedata);
    end
    n_checks++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_master: w0=%b w1=%b rd0=%h rd1=%h required 1 1 0 0", m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_m0_write();
    m0_address = 2'd0; m0_writedata = 32'hA; m0_write = 1'b1;
    step();
    n_checks++;
    if (s_chipselect !== 1'b1 || s_write_n !== 1'b0 || s_writedata !== 32'hA || m0_waitrequest !== 1'b1) begin
      n_fail++;
      $display("FAIL m0_write_issue: cs=%b wn=%b wd=%h w0=%b required 1 0 0000000a 1", s_chipselect, s_write_n, s_writedata, m0_waitrequest);
    end
    step();
    n_checks++;
    if (s_chipselect !== 1'b0 || s_write_n !== 1'b1 || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
      n_fail++;
      $display("FAIL m0_write_resp: cs=%b wn=%b w0=%b w1=%b required 0 1 0 1", s_chipselect, s_write_n, m0_waitrequest, m1_waitrequest);
    end
    step();
    m0_write = 1'b0;
    n_checks++;
    if (m0_waitrequest !== 1'b1 || out_port !== 4'hA) begin
      n_fail++;
      $display("FAIL m0_write_done: w0=%b out_port=%h required 1 a", m0_waitrequest, out_port);
    end
  endtask

  task automatic test_m1_read();
    m1_address = 2'd0; m1_read = 1'b1;
    step();
    n_checks++;
    if (s_chipselect !== 1'b1 || s_write_n !== 1'b1 || m1_waitrequest !== 1'b1) begin
      n_fail++;
      $display("FAIL m1_read_issue: cs=%b wn=%b w1=%b required 1 1 1", s_chipselect, s_write_n, m1_waitrequest);
    end
    step();
    n_checks++;
    if (m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1 || m1_readdata !== 32'h0000000A || s_write_n !== 1'b1) begin
      n_fail++;
      $display("FAIL m1_read_resp: w1=%b w0=%b rd1=%h wn=%b required 0 1 0000000a 1", m1_waitrequest, m0_waitrequest, m1_readdata, s_write_n);
    end
    step();
    m1_read = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp_w0, exp_w1, exp_cs;
    logic [31:0] exp_wd [6];
    exp_w0 = 6'b111011; exp_w1 = 6'b011111; exp_cs = 6'b010010;
    exp_wd = '{32'h0, 32'h3, 32'h3, 32'h3, 32'h5, 32'h5};
    m0_writedata = 32'h3; m1_writedata = 32'h5; m0_write = 1'b1; m1_write = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 3) m0_write = 1'b0;
      n_checks++;
      if (m0_waitrequest !== exp_w0[c] || m1_waitrequest !== exp_w1[c] || s_chipselect !== exp_cs[c] || s_writedata !== exp_wd[c]) begin
        n_fail++;
        $display("FAIL simultaneous_c%0d: w0=%b w1=%b cs=%b wd=%h required %b %b %b %h", c, m0_waitrequest, m1_waitrequest, s_chipselect, s_writedata, exp_w0[c], exp_w1[c], exp_cs[c], exp_wd[c]);
      end
    end
    step();
    m1_write = 1'b0;
    n_checks++;
    if (out_port !== 4'h5) begin
      n_fail++;
      $display("FAIL simultaneous_out: out_port=%h required 5", out_port);
    end
  endtask

  task automatic test_fairness();
    logic [12:0] exp_w0, exp_w1, exp_cs;
    exp_w0 = 13'b1_1110_1111_1011;
    exp_w1 = 13'b1_0111_1101_1111;
    exp_cs = 13'b0_0100_1001_0010;
    m0_writedata = 32'h1; m1_writedata = 32'h2; m0_write = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      if (c != 0) step();
      if (c == 1 || c == 7) m1_write = 1'b1;
      if (c == 6 || c == 12) m1_write = 1'b0;
      if (c == 12) m0_write = 1'b0;
      n_checks++;
      if (m0_waitrequest !== exp_w0[c] || m1_waitrequest !== exp_w1[c] || s_chipselect !== exp_cs[c]) begin
        n_fail++;
        $display("FAIL fairness_c%0d: w0=%b w1=%b cs=%b required %b %b %b", c, m0_waitrequest, m1_waitrequest, s_chipselect, exp_w0[c], exp_w1[c], exp_cs[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    m0_writedata = 32'h7; m0_write = 1'b1;
    step();
    n_checks++;
    if (s_chipselect !== 1'b1 || s_writedata !== 32'h7) begin
      n_fail++;
      $display("FAIL reset_mid_issue: cs=%b wd=%h required 1 00000007", s_chipselect, s_writedata);
    end
    reset = 1'b1; m0_write = 1'b0;
    step();
    reset = 1'b0;
    n_checks++;
    if (s_chipselect !== 1'b0 || s_write_n !== 1'b1 || s_writedata !== 32'h0 || m0_waitrequest !== 1'b1 || m0_readdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_after: cs=%b wn=%b wd=%h w0=%b rd0=%h required 0 1 0 1 0", s_chipselect, s_write_n, s_writedata, m0_waitrequest, m0_readdata);
    end
    for (int c = 0; c < 6; c++) begin
      step();
      n_checks++;
      if (s_chipselect !== 1'b0 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_mid_quiet_c%0d: cs=%b w0=%b w1=%b required 0 1 1", c, s_chipselect, m0_waitrequest, m1_waitrequest);
      end
    end
  endtask

  initial begin
    test_reset();
    test_m0_write();
    test_m1_read();
    test_simultaneous();
    test_fairness();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
